// File: rtl/mult_div_pkg.sv
// Shared constants and types for the iterative multiply/divide units in the execute stage.
package mult_div_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth code is {Q[0], q_1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_radix2_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// right shift of {ACC, Q, q_1} by one bit.
module booth_radix2_step
    import mult_div_pkg::*;
(
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            BOOTH_ADD: sum = acc_i + m_i;
            BOOTH_SUB: sum = acc_i - m_i;
            default:   sum = acc_i;
        endcase
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        q1_o  = q_i[0];
    end

endmodule

// File: rtl/thirty_two_bit_multiply.sv
// Sequential signed 32x32 Booth multiplier for MULT; 32 iterations, HI/LO result,
// start/done handshake shared with the iterative divider.
module thirty_two_bit_multiply
    import mult_div_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             do_mult,
    output logic             busy,
    output logic             value_ready,
    output logic             exception,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic             q1_q, q1_d;
    logic             busy_q, busy_d;
    logic             vr_q, vr_d;
    logic             exc_q, exc_d;

    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic             step_q1;
    logic             last_iter;

    booth_radix2_step u_step (
        .acc_i (acc_q),
        .q_i   (qr_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .q1_o  (step_q1)
    );

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update; a start in any state reloads the operands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        exc_d   = 1'b0;

        if (do_mult) begin
            state_d = RUN;
            m_d     = {A[WIDTH-1], A};
            acc_d   = '0;
            qr_d    = B;
            q1_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    acc_d = step_acc;
                    qr_d  = step_q;
                    q1_d  = step_q1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = DONE;
                        // Product fits in 32 bits only if HI is the sign extension of LO
                        exc_d   = (step_acc[WIDTH-1:0] != {WIDTH{step_q[WIDTH-1]}});
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN);
        vr_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            busy_q  <= 1'b0;
            vr_q    <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            busy_q  <= busy_d;
            vr_q    <= vr_d;
            exc_q   <= exc_d;
        end
    end

    assign busy        = busy_q;
    assign value_ready = vr_q;
    assign exception   = exc_q;
    assign out         = qr_q;
    assign out_hi      = acc_q[WIDTH-1:0];

endmodule
